mips_state_dumper: RTL and testbench

- Read-side companion to the 16-bit MIPS pipeline's register file and byte-addressed data memory.
- On request, freezes the CPU, reads all architectural registers and a data-memory window, and streams them out as one framed byte stream over a valid/ready interface.
- Used by the bench and the debug port to check results without hierarchical peeks into the core.
- Sits beside the core: it drives a read port into the register file and a read port into data memory, plus the CPU halt input.

---
 rtl/mips_state_dumper.sv | 219 +++++++++++++++++++++
 tb/tb_mips_state_dumper.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_state_dumper.sv
// Freezes the 16-bit MIPS core, then streams a framed snapshot of R0..R7 and a
// data-memory window (header, registers, memory bytes, XOR checksum) over valid/ready.
module mips_state_dumper #(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned REG_W       = 16,
  parameter int unsigned DMEM_AW     = 9,
  parameter int unsigned HALT_CYCLES = 4,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [DMEM_AW-1:0]          dump_base,
  input  logic [DMEM_AW:0]            dump_len,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic                        cpu_halt,
  output logic [$clog2(NUM_REGS)-1:0] rf_raddr,
  input  logic [REG_W-1:0]            rf_rdata,
  output logic [DMEM_AW-1:0]          dm_raddr,
  input  logic [7:0]                  dm_rdata,
  output logic                        out_valid,
  output logic [7:0]                  out_data,
  output logic                        out_last,
  input  logic                        out_ready
);

  localparam int unsigned RA_W = $clog2(NUM_REGS);
  localparam int unsigned HC_W = $clog2(HALT_CYCLES + 1);
  localparam logic [DMEM_AW:0] MAX_LEN = {1'b1, {DMEM_AW{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_HALT, S_HDR, S_REG, S_MEM, S_CSUM} state_t;

  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t             state_q, state_d;
  logic [HC_W-1:0]    halt_cnt_q, halt_cnt_d;
  logic [DMEM_AW-1:0] base_q, base_d;
  logic [DMEM_AW:0]   len_q, len_d;
  logic [DMEM_AW:0]   mem_idx_q, mem_idx_d;
  logic               mem_pend_q, mem_pend_d;
  logic               reg_lo_q, reg_lo_d;
  logic [7:0]         csum_q, csum_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               halt_q, halt_d;
  logic [RA_W-1:0]    rf_raddr_q, rf_raddr_d;
  logic [DMEM_AW-1:0] dm_raddr_q, dm_raddr_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               out_last_q, out_last_d;

  logic               acc;
  logic               slot_free;
  logic [7:0]         csum_acc;

  always_comb begin
    acc       = out_valid_q && out_ready;
    slot_free = !out_valid_q || out_ready;
    csum_acc  = acc ? csum_fold(csum_q, out_data_q) : csum_q;

    state_d     = state_q;
    halt_cnt_d  = halt_cnt_q;
    base_d      = base_q;
    len_d       = len_q;
    mem_idx_d   = mem_idx_q;
    mem_pend_d  = mem_pend_q;
    reg_lo_d    = reg_lo_q;
    csum_d      = csum_acc;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    halt_d      = halt_q;
    rf_raddr_d  = rf_raddr_q;
    dm_raddr_d  = dm_raddr_q;
    out_valid_d = acc ? 1'b0 : out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    // A new byte is loaded only when the output slot is empty or being drained.
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (dump_len > MAX_LEN) begin
            err_d = 1'b1;
          end else begin
            base_d     = dump_base;
            len_d      = dump_len;
            csum_d     = 8'h00;
            busy_d     = 1'b1;
            halt_d     = 1'b1;
            halt_cnt_d = '0;
            state_d    = S_HALT;
          end
        end
      end
      S_HALT: begin
        if (halt_cnt_q == HC_W'(HALT_CYCLES - 1)) state_d = S_HDR;
        else halt_cnt_d = halt_cnt_q + 1'b1;
      end
      S_HDR: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = HDR_BYTE;
          rf_raddr_d  = '0;
          reg_lo_d    = 1'b0;
          state_d     = S_REG;
        end
      end
      S_REG: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          if (!reg_lo_q) begin
            out_data_d = rf_rdata[REG_W-1 -: 8];
            reg_lo_d   = 1'b1;
          end else begin
            out_data_d = rf_rdata[7:0];
            reg_lo_d   = 1'b0;
            rf_raddr_d = rf_raddr_q + 1'b1;
            if (rf_raddr_q == RA_W'(NUM_REGS - 1)) begin
              if (len_q == '0) begin
                state_d = S_CSUM;
              end else begin
                dm_raddr_d = base_q;
                mem_idx_d  = '0;
                mem_pend_d = 1'b0;
                state_d    = S_MEM;
              end
            end
          end
        end
      end
      S_MEM: begin
        // First cycle presents the address, second cycle has the registered read data.
        if (!mem_pend_q) begin
          mem_pend_d = 1'b1;
        end else if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = dm_rdata;
          dm_raddr_d  = dm_raddr_q + 1'b1;
          mem_pend_d  = 1'b0;
          mem_idx_d   = mem_idx_q + 1'b1;
          if (mem_idx_q == len_q - 1'b1) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (!out_last_q) begin
          if (slot_free) begin
            out_valid_d = 1'b1;
            out_data_d  = csum_acc;
            out_last_d  = 1'b1;
          end
        end else if (acc) begin
          out_last_d = 1'b0;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          halt_d     = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      halt_cnt_q  <= '0;
      base_q      <= '0;
      len_q       <= '0;
      mem_idx_q   <= '0;
      mem_pend_q  <= 1'b0;
      reg_lo_q    <= 1'b0;
      csum_q      <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      halt_q      <= 1'b0;
      rf_raddr_q  <= '0;
      dm_raddr_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_cnt_q  <= halt_cnt_d;
      base_q      <= base_d;
      len_q       <= len_d;
      mem_idx_q   <= mem_idx_d;
      mem_pend_q  <= mem_pend_d;
      reg_lo_q    <= reg_lo_d;
      csum_q      <= csum_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      halt_q      <= halt_d;
      rf_raddr_q  <= rf_raddr_d;
      dm_raddr_q  <= dm_raddr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_halt  = halt_q;
  assign rf_raddr  = rf_raddr_q;
  assign dm_raddr  = dm_raddr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_mips_state_dumper.sv
// Bench for mips_state_dumper: register file and data memory models, a stream
// monitor, and per-scenario tasks comparing frames against a frame-building model.
module tb_mips_state_dumper;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  dump_base = '0;
  logic [9:0]  dump_len = '0;
  logic        out_ready = 1'b0;
  logic        busy, done, err, cpu_halt, out_valid, out_last;
  logic [2:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic [8:0]  dm_raddr;
  logic [7:0]  dm_rdata, out_data;

  logic [15:0] rf [8];
  logic [7:0]  dm [512];

  logic [7:0]  got[$];
  bit          got_last[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  stall_log[$];
  int n_acc = 0, n_done = 0, n_err = 0, stab_viol = 0, halt_viol = 0;
  int acc_base = 0, arm_id = 0, rdy_mode = 0;
  int n_checks = 0, n_errors = 0;

  mips_state_dumper dut (
    .clk(clk), .rst(rst), .start(start), .dump_base(dump_base), .dump_len(dump_len),
    .busy(busy), .done(done), .err(err), .cpu_halt(cpu_halt),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dm_raddr(dm_raddr), .dm_rdata(dm_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  assign rf_rdata = rf[rf_raddr];
  always_ff @(posedge clk) dm_rdata <= dm[dm_raddr];

  // Sink: 0 = always ready, 1 = random, 2 = three-cycle stall on frame byte 4.
  initial begin
    int stall_left;
    int done_id;
    stall_left = 0;
    done_id = 0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (rdy_mode == 2 && done_id != arm_id && out_valid && (n_acc - acc_base) == 4) begin
        out_ready = 1'b0;
        stall_left = 2;
        done_id = arm_id;
      end else if (rdy_mode == 1) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor sampled mid-cycle: a byte seen with valid&ready here is taken at the next edge.
  initial begin
    bit stall_prev;
    logic [7:0] data_prev;
    logic last_prev;
    stall_prev = 0;
    data_prev = '0;
    last_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (stall_prev && !out_valid) stab_viol++;
        if (stall_prev && out_valid && (out_data !== data_prev || out_last !== last_prev)) stab_viol++;
        if (out_valid && out_ready) begin
          got.push_back(out_data);
          got_last.push_back(out_last);
          n_acc++;
        end
        if (out_valid && !out_ready) stall_log.push_back(out_data);
        stall_prev = out_valid && !out_ready;
        data_prev = out_data;
        last_prev = out_last;
        if (busy !== cpu_halt) halt_viol++;
        if (done === 1'b1) n_done++;
        if (err === 1'b1) n_err++;
      end else begin
        stall_prev = 0;
      end
    end
  end

  task automatic clear_all();
    for (int r = 0; r < 8; r++) rf[r] = 16'h0000;
    for (int a = 0; a < 512; a++) dm[a] = 8'h00;
  endtask

  // Expected frame straight from the frame definition.
  function automatic void build_exp(input int base, input int len);
    logic [7:0] x;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int r = 0; r < 8; r++) begin
      exp_q.push_back(rf[r][15:8]);
      exp_q.push_back(rf[r][7:0]);
    end
    for (int i = 0; i < len; i++) exp_q.push_back(dm[(base + i) % 512]);
    x = 8'h00;
    foreach (exp_q[k]) x = x ^ exp_q[k];
    exp_q.push_back(x);
  endfunction

  task automatic run_frame(input logic [8:0] base, input logic [9:0] len, input int mode,
                           input bit extra, output bit tmo, output int fbase);
    int d0, cyc;
    rdy_mode = mode;
    arm_id++;
    @(posedge clk);
    #1;
    fbase = got.size();
    acc_base = n_acc;
    d0 = n_done;
    start = 1'b1;
    dump_base = base;
    dump_len = len;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (n_done == d0 && cyc < 6000) begin
      if (extra && cyc == 3) begin
        start = 1'b1; dump_base = 9'd0; dump_len = 10'd9;
      end else if (extra && cyc == 8) begin
        start = 1'b1; dump_len = 10'd600;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    tmo = (n_done == d0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, err, cpu_halt, out_valid, out_last} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %06b, want 000000", {busy, done, err, cpu_halt, out_valid, out_last});
    end
    n_checks++;
    if (out_data !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_data: got %02h, want 00", out_data);
    end
    n_checks++;
    if (rf_raddr !== 3'd0 || dm_raddr !== 9'd0) begin
      n_errors++;
      $display("FAIL reset_addr: got rf %0d dm %0d, want 0 0", rf_raddr, dm_raddr);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    bit tmo;
    int fb, d0, h0, s0;
    clear_all();
    rf[1] = 16'd5; rf[2] = 16'd3; rf[3] = 16'd8;
    dm[4] = 8'h00; dm[5] = 8'h08;
    build_exp(4, 2);
    d0 = n_done; h0 = halt_viol; s0 = stab_viol;
    run_frame(9'd4, 10'd2, 0, 0, tmo, fb);
    n_checks++;
    if (tmo) begin n_errors++; $display("FAIL basic_timeout: done not seen, want done"); end
    n_checks++;
    if (got.size() - fb !== 20) begin
      n_errors++; $display("FAIL basic_len: got %0d bytes, want 20", got.size() - fb);
    end
    for (int i = 0; i < exp_q.size() && fb + i < got.size(); i++) begin
      n_checks++;
      if (got[fb+i] !== exp_q[i] || got_last[fb+i] !== (i == exp_q.size() - 1)) begin
        n_errors++;
        $display("FAIL basic_byte%0d: got %02h last %0b, want %02h last %0b", i, got[fb+i], got_last[fb+i], exp_q[i], (i == exp_q.size() - 1));
      end
    end
    n_checks++;
    if (fb + 19 < got.size() && got[fb+19] !== 8'hA3) begin
      n_errors++; $display("FAIL basic_csum: got %02h, want A3", got[fb+19]);
    end
    n_checks++;
    if (n_done - d0 !== 1 || busy !== 1'b0 || cpu_halt !== 1'b0) begin
      n_errors++; $display("FAIL basic_done: got dones %0d busy %0b halt %0b, want 1 0 0", n_done - d0, busy, cpu_halt);
    end
    n_checks++;
    if (halt_viol !== h0 || stab_viol !== s0) begin
      n_errors++; $display("FAIL basic_halt_stream: got halt_viol %0d stab_viol %0d, want 0 0", halt_viol - h0, stab_viol - s0);
    end
  endtask

  task automatic test_len0();
    bit tmo;
    int fb;
    clear_all();
    build_exp(0, 0);
    run_frame(9'd77, 10'd0, 0, 0, tmo, fb);
    n_checks++;
    if (tmo || got.size() - fb !== 18) begin
      n_errors++; $display("FAIL len0_len: got %0d bytes tmo %0b, want 18 0", got.size() - fb, tmo);
    end
    for (int i = 0; i < exp_q.size() && fb + i < got.size(); i++) begin
      n_checks++;
      if (got[fb+i] !== exp_q[i] || got_last[fb+i] !== (i == exp_q.size() - 1)) begin
        n_errors++;
        $display("FAIL len0_byte%0d: got %02h last %0b, want %02h", i, got[fb+i], got_last[fb+i], exp_q[i]);
      end
    end
    n_checks++;
    if (fb + 17 < got.size() && got[fb+17] !== 8'hA5) begin
      n_errors++; $display("FAIL len0_csum: got %02h, want A5", got[fb+17]);
    end
  endtask

  task automatic test_wrap();
    bit tmo;
    int fb;
    logic [31:0] mem_bytes;
    clear_all();
    dm[510] = 8'h11; dm[511] = 8'h22; dm[0] = 8'h33; dm[1] = 8'h44; dm[2] = 8'h55;
    build_exp(510, 4);
    run_frame(9'd510, 10'd4, 0, 0, tmo, fb);
    n_checks++;
    if (tmo || got.size() - fb !== 22) begin
      n_errors++; $display("FAIL wrap_len: got %0d bytes tmo %0b, want 22 0", got.size() - fb, tmo);
    end
    mem_bytes = '0;
    if (fb + 20 < got.size()) mem_bytes = {got[fb+17], got[fb+18], got[fb+19], got[fb+20]};
    n_checks++;
    if (mem_bytes !== 32'h11223344) begin
      n_errors++; $display("FAIL wrap_mem: got %08h, want 11223344", mem_bytes);
    end
    n_checks++;
    if (fb + 21 < got.size() && (got[fb+21] !== exp_q[21] || got_last[fb+21] !== 1'b1)) begin
      n_errors++; $display("FAIL wrap_csum: got %02h, want %02h", got[fb+21], exp_q[21]);
    end
  endtask

  task automatic test_backpressure();
    bit tmo;
    int fb, s0, l0, h0;
    clear_all();
    rf[1] = 16'd5; rf[2] = 16'd3; rf[3] = 16'd8;
    dm[5] = 8'h08;
    build_exp(4, 2);
    s0 = stab_viol; l0 = stall_log.size(); h0 = halt_viol;
    run_frame(9'd4, 10'd2, 2, 0, tmo, fb);
    n_checks++;
    if (tmo || got.size() - fb !== 20) begin
      n_errors++; $display("FAIL bp_len: got %0d bytes tmo %0b, want 20 0", got.size() - fb, tmo);
    end
    for (int i = 0; i < exp_q.size() && fb + i < got.size(); i++) begin
      n_checks++;
      if (got[fb+i] !== exp_q[i]) begin
        n_errors++; $display("FAIL bp_byte%0d: got %02h, want %02h", i, got[fb+i], exp_q[i]);
      end
    end
    n_checks++;
    if (stall_log.size() - l0 !== 3) begin
      n_errors++; $display("FAIL bp_stall_cycles: got %0d, want 3", stall_log.size() - l0);
    end
    for (int i = l0; i < stall_log.size(); i++) begin
      n_checks++;
      if (stall_log[i] !== 8'h05) begin
        n_errors++; $display("FAIL bp_hold: got %02h, want 05", stall_log[i]);
      end
    end
    n_checks++;
    if (stab_viol !== s0 || halt_viol !== h0) begin
      n_errors++; $display("FAIL bp_stable: got stab %0d halt %0d, want 0 0", stab_viol - s0, halt_viol - h0);
    end
  endtask

  task automatic test_illegal_len();
    int e0, a0;
    bit quiet;
    logic [9:0] bad [2];
    bad[0] = 10'd513;
    bad[1] = 10'd1023;
    for (int k = 0; k < 2; k++) begin
      e0 = n_err; a0 = n_acc;
      @(posedge clk);
      #1;
      start = 1'b1; dump_base = 9'd3; dump_len = bad[k];
      @(posedge clk);
      #1;
      start = 1'b0;
      n_checks++;
      if (err !== 1'b1) begin
        n_errors++; $display("FAIL illegal_err%0d: got %0b, want 1", k, err);
      end
      quiet = 1;
      repeat (6) begin
        @(posedge clk);
        #1;
        if (out_valid !== 1'b0 || busy !== 1'b0 || cpu_halt !== 1'b0 || err !== 1'b0) quiet = 0;
      end
      n_checks++;
      if (!quiet || n_err - e0 !== 1 || n_acc !== a0) begin
        n_errors++;
        $display("FAIL illegal_quiet%0d: got quiet %0b errs %0d bytes %0d, want 1 1 0", k, quiet, n_err - e0, n_acc - a0);
      end
    end
  endtask

  task automatic test_start_while_busy();
    bit tmo;
    int fb, d0, e0;
    clear_all();
    for (int r = 0; r < 8; r++) rf[r] = 16'(r * 16'h0101 + 1);
    for (int a = 100; a < 103; a++) dm[a] = 8'(a);
    build_exp(100, 3);
    d0 = n_done; e0 = n_err;
    run_frame(9'd100, 10'd3, 0, 1, tmo, fb);
    repeat (30) @(posedge clk);
    #1;
    n_checks++;
    if (tmo || got.size() - fb !== exp_q.size()) begin
      n_errors++; $display("FAIL busy_len: got %0d bytes tmo %0b, want %0d 0", got.size() - fb, tmo, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && fb + i < got.size(); i++) begin
      n_checks++;
      if (got[fb+i] !== exp_q[i]) begin
        n_errors++; $display("FAIL busy_byte%0d: got %02h, want %02h", i, got[fb+i], exp_q[i]);
      end
    end
    n_checks++;
    if (n_done - d0 !== 1 || n_err !== e0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL busy_ignore: got dones %0d errs %0d busy %0b, want 1 0 0", n_done - d0, n_err - e0, busy);
    end
  endtask

  task automatic test_mid_reset();
    bit tmo;
    int fb, d0, cyc;
    clear_all();
    for (int a = 0; a < 64; a++) dm[a] = 8'($urandom);
    rdy_mode = 0;
    @(posedge clk);
    #1;
    acc_base = n_acc; d0 = n_done;
    start = 1'b1; dump_base = 9'd10; dump_len = 10'd40;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while ((n_acc - acc_base) < 19 && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_checks++;
    if (cyc >= 500) begin
      n_errors++; $display("FAIL midrst_reach_mem: got %0d bytes, want 19", n_acc - acc_base);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, err, cpu_halt, out_valid, out_last} !== 6'b0 || out_data !== 8'h00 ||
        rf_raddr !== 3'd0 || dm_raddr !== 9'd0) begin
      n_errors++;
      $display("FAIL midrst_outputs: got ctrl %06b data %02h rf %0d dm %0d, want 0",
               {busy, done, err, cpu_halt, out_valid, out_last}, out_data, rf_raddr, dm_raddr);
    end
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (n_done !== d0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_errors++; $display("FAIL midrst_no_done: got dones %0d busy %0b valid %0b, want 0 0 0", n_done - d0, busy, out_valid);
    end
    rf[6] = 16'hBEEF;
    build_exp(7, 5);
    run_frame(9'd7, 10'd5, 0, 0, tmo, fb);
    n_checks++;
    if (tmo || got.size() - fb !== exp_q.size()) begin
      n_errors++; $display("FAIL midrst_next_len: got %0d bytes tmo %0b, want %0d 0", got.size() - fb, tmo, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && fb + i < got.size(); i++) begin
      n_checks++;
      if (got[fb+i] !== exp_q[i]) begin
        n_errors++; $display("FAIL midrst_next_byte%0d: got %02h, want %02h", i, got[fb+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bit tmo;
    int fb, base, len, s0, h0, bad;
    for (int it = 0; it < 6; it++) begin
      for (int r = 0; r < 8; r++) rf[r] = 16'($urandom);
      for (int a = 0; a < 512; a++) dm[a] = 8'($urandom);
      base = $urandom_range(0, 511);
      len = (it == 0) ? 512 : (it == 1) ? 1 : $urandom_range(0, 80);
      build_exp(base, len);
      s0 = stab_viol; h0 = halt_viol;
      run_frame(9'(base), 10'(len), 1, 0, tmo, fb);
      n_checks++;
      if (tmo || got.size() - fb !== 18 + len) begin
        n_errors++;
        $display("FAIL rand%0d_len: got %0d bytes tmo %0b, want %0d 0 (base %0d)", it, got.size() - fb, tmo, 18 + len, base);
      end
      bad = -1;
      for (int i = 0; i < exp_q.size() && fb + i < got.size(); i++)
        if (bad < 0 && (got[fb+i] !== exp_q[i] || got_last[fb+i] !== (i == exp_q.size() - 1))) bad = i;
      n_checks++;
      if (bad >= 0) begin
        n_errors++;
        $display("FAIL rand%0d_byte%0d: got %02h, want %02h (base %0d len %0d)", it, bad, got[fb+bad], exp_q[bad], base, len);
      end
      n_checks++;
      if (stab_viol !== s0 || halt_viol !== h0) begin
        n_errors++; $display("FAIL rand%0d_rules: got stab %0d halt %0d, want 0 0", it, stab_viol - s0, halt_viol - h0);
      end
    end
  endtask

  initial begin
    clear_all();
    test_reset();
    test_basic();
    test_len0();
    test_wrap();
    test_backpressure();
    test_illegal_len();
    test_start_while_busy();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
